// File: rtl/sensor_ni_pkg.sv
// Shared types and helpers for the sensor network-interface FIFO write controller.
package sensor_ni_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GAP  = 3'd1,
    ARM  = 3'd2,
    HEAD = 3'd3,
    DATA = 3'd4
  } ni_state_e;

  localparam logic [2:0] TAG_HEAD = 3'b000;
  localparam logic [2:0] TAG_DATA = 3'b110;

  // Widest flit the pack helper can build; callers truncate to their FLIT_W.
  localparam int FLIT_MAX_W = 64;

  // Place the 3-bit tag in the top bits of a flit_w-wide flit; payload sits
  // right-aligned and the bits in between stay zero.
  function automatic logic [FLIT_MAX_W-1:0] pack_flit(
    input logic [2:0]            tag,
    input logic [FLIT_MAX_W-1:0] payload,
    input int unsigned           flit_w
  );
    logic [FLIT_MAX_W-1:0] tag_ext;
    tag_ext   = {{(FLIT_MAX_W-3){1'b0}}, tag};
    pack_flit = payload | (tag_ext << (flit_w - 32'd3));
  endfunction

endpackage

// File: rtl/sensor_ni_interval_timer.sv
// Loadable interval counter: captures the interval on load, counts up from
// zero while enabled and flags done when the count reaches the interval.
module sensor_ni_interval_timer #(
  parameter int RATE_W = 14
) (
  input  logic              clk_division,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              count_en,
  input  logic [RATE_W-1:0] rate_in,
  output logic              done
);

  logic [RATE_W-1:0] rate_q;
  logic [RATE_W-1:0] gap_cnt;

  // Interval capture and gap counting; clr wins over load and count.
  always_ff @(posedge clk_division or negedge rst_n) begin
    if (!rst_n) begin
      rate_q  <= {RATE_W{1'b0}};
      gap_cnt <= {RATE_W{1'b0}};
    end else if (clr) begin
      rate_q  <= {RATE_W{1'b0}};
      gap_cnt <= {RATE_W{1'b0}};
    end else if (load) begin
      rate_q  <= rate_in;
      gap_cnt <= {RATE_W{1'b0}};
    end else if (count_en && !done) begin
      gap_cnt <= gap_cnt + RATE_W'(1);
    end
  end

  assign done = (gap_cnt == rate_q);

endmodule

// File: rtl/sensor_ni_fifo_wrctrl_p.sv
// Sensor NI FIFO write controller: after the FIFO drains, waits the injection
// interval, strobes the sensors, then walks every slot for NUM_FRAMES frames
// writing a header/data flit pair per enabled slot under FIFO backpressure.
module sensor_ni_fifo_wrctrl_p
  import sensor_ni_pkg::*;
#(
  parameter int FLIT_W      = 16,
  parameter int CORE_ADDR_W = 4,
  parameter int SLOT_IDX_W  = 4,
  parameter int FRAME_W     = 8,
  parameter int NUM_FRAMES  = 256,
  parameter int RATE_W      = 14
) (
  input  logic                     clk_division,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [CORE_ADDR_W-1:0]   core_address,
  input  logic [RATE_W-1:0]        inject_rate,
  input  logic [(2**SLOT_IDX_W)-1:0] slot_mask,
  input  logic                     fifo_empty,
  input  logic                     fifo_full,
  output logic                     sample_en,
  output logic                     fifo_wr,
  output logic [FLIT_W-1:0]        fifo_data,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int NSLOT = 2**SLOT_IDX_W;
  localparam logic [SLOT_IDX_W-1:0] LAST_SLOT  = SLOT_IDX_W'(NSLOT-1);
  localparam logic [FRAME_W-1:0]    LAST_FRAME = FRAME_W'(NUM_FRAMES-1);

  ni_state_e               state_r;
  logic [SLOT_IDX_W-1:0]   slot_idx_r;
  logic [FRAME_W-1:0]      frame_cnt_r;
  logic                    frame_done_r;

  logic                    gap_done_s;
  logic                    slot_on_s;
  logic                    step_s;
  logic                    wr_s;
  logic [FLIT_W-1:0]       data_s;

  sensor_ni_interval_timer #(
    .RATE_W (RATE_W)
  ) u_gap_timer (
    .clk_division (clk_division),
    .rst_n        (rst_n),
    .clr          (!enable),
    .load         (enable && fifo_empty && (state_r == IDLE)),
    .count_en     (state_r == GAP),
    .rate_in      (inject_rate),
    .done         (gap_done_s)
  );

  assign slot_on_s = slot_mask[slot_idx_r];

  // Slot advance happens on a skipped header or on an accepted data flit.
  always_comb begin
    step_s = 1'b0;
    if ((state_r == HEAD) && !slot_on_s) begin
      step_s = 1'b1;
    end else if ((state_r == DATA) && !fifo_full) begin
      step_s = 1'b1;
    end else begin
      step_s = 1'b0;
    end
  end

  // Write strobe and flit; both are forced low outside an accepted write slot.
  always_comb begin
    wr_s   = 1'b0;
    data_s = {FLIT_W{1'b0}};
    case (state_r)
      HEAD: begin
        if (enable && !fifo_full && slot_on_s) begin
          wr_s   = 1'b1;
          data_s = FLIT_W'(pack_flit(TAG_HEAD, FLIT_MAX_W'({core_address, slot_idx_r}), FLIT_W));
        end else begin
          wr_s   = 1'b0;
          data_s = {FLIT_W{1'b0}};
        end
      end
      DATA: begin
        if (enable && !fifo_full) begin
          wr_s   = 1'b1;
          data_s = FLIT_W'(pack_flit(TAG_DATA, FLIT_MAX_W'(frame_cnt_r), FLIT_W));
        end else begin
          wr_s   = 1'b0;
          data_s = {FLIT_W{1'b0}};
        end
      end
      default: begin
        wr_s   = 1'b0;
        data_s = {FLIT_W{1'b0}};
      end
    endcase
  end

  // Main FSM with slot/frame counters and the end-of-burst pulse.
  always_ff @(posedge clk_division or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      slot_idx_r   <= {SLOT_IDX_W{1'b0}};
      frame_cnt_r  <= {FRAME_W{1'b0}};
      frame_done_r <= 1'b0;
    end else if (!enable) begin
      state_r      <= IDLE;
      slot_idx_r   <= {SLOT_IDX_W{1'b0}};
      frame_cnt_r  <= {FRAME_W{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (fifo_empty) state_r <= GAP;
        end
        GAP: begin
          if (gap_done_s) state_r <= ARM;
        end
        ARM: begin
          slot_idx_r  <= {SLOT_IDX_W{1'b0}};
          frame_cnt_r <= {FRAME_W{1'b0}};
          state_r     <= HEAD;
        end
        HEAD, DATA: begin
          if (step_s) begin
            if ((slot_idx_r == LAST_SLOT) && (frame_cnt_r == LAST_FRAME)) begin
              state_r      <= IDLE;
              slot_idx_r   <= {SLOT_IDX_W{1'b0}};
              frame_cnt_r  <= {FRAME_W{1'b0}};
              frame_done_r <= 1'b1;
            end else begin
              slot_idx_r <= slot_idx_r + SLOT_IDX_W'(1);
              if (slot_idx_r == LAST_SLOT) frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
              state_r <= HEAD;
            end
          end else if ((state_r == HEAD) && !fifo_full) begin
            state_r <= DATA;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign sample_en  = enable && (state_r == ARM);
  assign fifo_wr    = wr_s;
  assign fifo_data  = data_s;
  assign frame_done = frame_done_r;
  assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_sensor_ni_fifo_wrctrl_p.sv
// Directed self-checking bench for the sensor NI FIFO write controller.
module tb_sensor_ni_fifo_wrctrl_p;

  logic        clk_division = 1'b0;
  logic        rst_n        = 1'b0;
  logic        enable       = 1'b0;
  logic        enable2      = 1'b0;
  logic [3:0]  core_address = 4'h4;
  logic [13:0] inject_rate  = 14'd0;
  logic [15:0] slot_mask    = 16'h0000;
  logic        fifo_empty   = 1'b0;
  logic        fifo_full    = 1'b0;

  logic        sample_en, fifo_wr, frame_done, busy;
  logic [15:0] fifo_data;
  logic        sample_en2, fifo_wr2, frame_done2, busy2;
  logic [15:0] fifo_data2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_division = ~clk_division;

  sensor_ni_fifo_wrctrl_p dut (
    .clk_division (clk_division), .rst_n (rst_n), .enable (enable),
    .core_address (core_address), .inject_rate (inject_rate), .slot_mask (slot_mask),
    .fifo_empty (fifo_empty), .fifo_full (fifo_full), .sample_en (sample_en),
    .fifo_wr (fifo_wr), .fifo_data (fifo_data), .frame_done (frame_done), .busy (busy)
  );

  sensor_ni_fifo_wrctrl_p #(.NUM_FRAMES(2)) dut2 (
    .clk_division (clk_division), .rst_n (rst_n), .enable (enable2),
    .core_address (core_address), .inject_rate (inject_rate), .slot_mask (slot_mask),
    .fifo_empty (fifo_empty), .fifo_full (fifo_full), .sample_en (sample_en2),
    .fifo_wr (fifo_wr2), .fifo_data (fifo_data2), .frame_done (frame_done2), .busy (busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next falling edge: outputs settled, inputs safe to drive.
  task automatic tick();
    @(negedge clk_division);
    #1;
  endtask

  initial begin
    int found, cyc, wr_n, fd_n, pre;
    logic [15:0] exp_flit;

    // ---------------- reset values ----------------
    repeat (2) tick();
    chk("rst_sample_en", 32'(sample_en), 32'd0);
    chk("rst_fifo_wr", 32'(fifo_wr), 32'd0);
    chk("rst_fifo_data", 32'(fifo_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // ---------------- test 1: rate 5, slot 0 only, full burst ----------------
    inject_rate = 14'd5; slot_mask = 16'h0001; fifo_empty = 1'b1; enable = 1'b1;
    found = 0; cyc = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      tick();
      if (sample_en) found = 1;
      else if (busy) cyc++;
    end
    chk("t1_arm_seen", 32'(found), 32'd1);
    chk("t1_gap_cycles", 32'(cyc), 32'd6);
    fifo_empty = 1'b0;
    wr_n = 0; fd_n = 0;
    for (int i = 0; i < 6000 && fd_n == 0; i++) begin
      tick();
      if (i == 0) chk("t1_sample_one_cycle", 32'(sample_en), 32'd0);
      if (fifo_wr) begin
        exp_flit = (wr_n % 2 == 0) ? 16'h0040 : (16'hC000 | 16'(wr_n / 2));
        chk("t1_flit", 32'(fifo_data), 32'(exp_flit));
        wr_n++;
      end
      if (frame_done) fd_n++;
    end
    chk("t1_write_count", 32'(wr_n), 32'd512);
    chk("t1_frame_done_seen", 32'(fd_n), 32'd1);
    tick();
    chk("t1_frame_done_pulse", 32'(frame_done), 32'd0);
    chk("t1_idle_after", 32'(busy), 32'd0);

    // ---------------- test 2: backpressure on slot-15 header ----------------
    slot_mask = 16'h8001; inject_rate = 14'd0; fifo_empty = 1'b1;
    found = 0; pre = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      tick();
      if (sample_en) fifo_empty = 1'b0;
      if (fifo_wr) begin
        if (fifo_data == 16'h004F) found = 1;
        else pre++;
      end
    end
    chk("t2_slot15_header_seen", 32'(found), 32'd1);
    chk("t2_slot0_pair_before", 32'(pre), 32'd2);
    fifo_full = 1'b1;
    #1;
    chk("t2_full_gate_wr", 32'(fifo_wr), 32'd0);
    chk("t2_full_gate_data", 32'(fifo_data), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("t2_full_hold_wr", 32'(fifo_wr), 32'd0);
    end
    tick();
    fifo_full = 1'b0;
    #1;
    chk("t2_release_wr", 32'(fifo_wr), 32'd1);
    chk("t2_release_header", 32'(fifo_data), 32'h004F);
    tick();
    chk("t2_data_wr", 32'(fifo_wr), 32'd1);
    chk("t2_data_flit", 32'(fifo_data), 32'hC000);
    tick();
    chk("t2_next_header", 32'(fifo_data), 32'h0040);
    tick();
    chk("t2_next_data", 32'(fifo_data), 32'hC001);

    // ---------------- test 4: enable dropped mid-DATA ----------------
    enable = 1'b0;
    #1;
    chk("t4_wr_gated", 32'(fifo_wr), 32'd0);
    chk("t4_data_zero", 32'(fifo_data), 32'd0);
    tick();
    chk("t4_idle_next", 32'(busy), 32'd0);
    enable = 1'b1; fifo_empty = 1'b1;
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      tick();
      if (sample_en) fifo_empty = 1'b0;
      if (fifo_wr) found = 1;
    end
    chk("t4_restart_header", 32'(fifo_data), 32'h0040);
    tick();
    chk("t4_restart_data", 32'(fifo_data), 32'hC000);
    enable = 1'b0;
    tick();

    // ---------------- test 5: async reset mid-GAP ----------------
    inject_rate = 14'd20; fifo_empty = 1'b1; enable = 1'b1;
    repeat (4) tick();
    fifo_empty = 1'b0;
    chk("t5_in_gap", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_wr", 32'(fifo_wr), 32'd0);
    chk("t5_async_sample", 32'(sample_en), 32'd0);
    chk("t5_async_done", 32'(frame_done), 32'd0);
    #1;
    rst_n = 1'b1;
    fifo_empty = 1'b1;
    found = 0; cyc = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      tick();
      if (sample_en) found = 1;
      else if (busy) cyc++;
    end
    chk("t5_restart_arm", 32'(found), 32'd1);
    chk("t5_restart_gap_cycles", 32'(cyc), 32'd21);
    enable = 1'b0; fifo_empty = 1'b0;
    tick();

    // ---------------- test 6: rate 0 waits for empty FIFO ----------------
    inject_rate = 14'd0; enable = 1'b1;
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy) cyc++;
    end
    chk("t6_stays_idle", 32'(cyc), 32'd0);
    fifo_empty = 1'b1;
    tick();
    chk("t6_gap_busy", 32'(busy), 32'd1);
    chk("t6_gap_no_sample", 32'(sample_en), 32'd0);
    tick();
    chk("t6_arm_sample", 32'(sample_en), 32'd1);
    enable = 1'b0; fifo_empty = 1'b0;
    tick();
    chk("t6_disabled_idle", 32'(busy), 32'd0);

    // ---------------- test 3: all-zero mask, two frames ----------------
    slot_mask = 16'h0000; fifo_empty = 1'b1; enable2 = 1'b1;
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      tick();
      if (sample_en2) found = 1;
    end
    chk("t3_arm_seen", 32'(found), 32'd1);
    fifo_empty = 1'b0;
    // 32 skip cycles follow the ARM cycle; frame_done shows on the cycle after the last skip.
    found = 0; cyc = 0; wr_n = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      tick();
      cyc++;
      if (fifo_wr2) wr_n++;
      if (frame_done2) found = 1;
    end
    chk("t3_done_seen", 32'(found), 32'd1);
    chk("t3_done_delay", 32'(cyc), 32'd33);
    chk("t3_no_writes", 32'(wr_n), 32'd0);
    tick();
    chk("t3_done_pulse", 32'(frame_done2), 32'd0);
    enable2 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
